// File: rtl/icache_refill_axi.sv
// Icache miss-refill engine: one AXI4 read burst per line, early critical-word delivery.
// Define ICACHE_REFILL_CWF_EN for a critical-word-first WRAP burst; default is an INCR burst from the line base.
module icache_refill_axi #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         BLOCK_SIZE = 5,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  output logic                            crit_valid,
  output logic [31:0]                     crit_data,
  output logic                            line_valid,
  output logic [ADDR_WIDTH-1:0]           line_addr,
  output logic [(2**(BLOCK_SIZE+3))-1:0]  line_data,
  output logic                            line_err,
  output logic [3:0]                      arid,
  output logic [ADDR_WIDTH-1:0]           araddr,
  output logic [7:0]                      arlen,
  output logic [2:0]                      arsize,
  output logic [1:0]                      arburst,
  output logic                            arvalid,
  input  logic                            arready,
  input  logic [3:0]                      rid,
  input  logic [31:0]                     rdata,
  input  logic [1:0]                      rresp,
  input  logic                            rlast,
  input  logic                            rvalid,
  output logic                            rready
);

  localparam int W         = 2**(BLOCK_SIZE-2);
  localparam int OFF_W     = BLOCK_SIZE-2;
  localparam int LINE_BITS = W*32;

`ifdef ICACHE_REFILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [OFF_W-1:0]       ptr_q, ptr_d;
  logic [OFF_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [LINE_BITS-1:0]   line_q, line_d;
  logic                   crit_valid_q, crit_valid_d;
  logic [31:0]            crit_data_q, crit_data_d;

  logic [ADDR_WIDTH-1:0]  line_base;
  logic [OFF_W-1:0]       off;
  logic                   last_beat;

  assign line_base = {addr_q[ADDR_WIDTH-1:BLOCK_SIZE], {BLOCK_SIZE{1'b0}}};
  assign off       = addr_q[BLOCK_SIZE-1:2];
  assign last_beat = (cnt_q == OFF_W'(W-1));

  // AR payload is a pure function of the latched address, so it is stable while arvalid waits.
  assign arid    = AXI_ID;
  assign arlen   = 8'(W-1);
  assign arsize  = 3'b010;
  assign arburst = CWF ? 2'b10 : 2'b01;
  assign araddr  = CWF ? addr_q : line_base;

  assign line_addr  = line_base;
  assign line_data  = line_q;
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign line_err   = (state_q == S_DONE) && err_q;

  // rid is ignored (single outstanding burst); rresp[0] only distinguishes EXOKAY.
  logic unused_bits;
  assign unused_bits = ^{rid, rresp[0], addr_q[1:0]};

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    line_d       = line_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    req_ready    = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    line_valid   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr & ~ADDR_WIDTH'(3);
          ptr_d   = CWF ? req_addr[BLOCK_SIZE-1:2] : '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          line_d[{ptr_q, 5'b00000} +: 32] = rdata;
          ptr_d = ptr_q + OFF_W'(1);
          cnt_d = cnt_q + OFF_W'(1);
          if (ptr_q == off) begin
            crit_valid_d = 1'b1;
            crit_data_d  = rdata;
          end
          if (rresp[1] || (rlast != last_beat)) err_d = 1'b1;
          // The beat count, not rlast, closes the burst.
          if (last_beat) state_d = S_DONE;
        end
      end
      S_DONE: begin
        line_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      // NOTE: the line buffer is reset because it drives line_data directly and must read zero after reset.
      line_q       <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      line_q       <= line_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
    end
  end

endmodule

// File: tb/tb_icache_refill_axi.sv
// Directed bench for icache_refill_axi: the bench plays the AXI slave, a scoreboard checks crit/line outputs.
module tb_icache_refill_axi;

`ifdef ICACHE_REFILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         crit_valid;
  logic [31:0]  crit_data;
  logic         line_valid;
  logic [31:0]  line_addr;
  logic [255:0] line_data;
  logic         line_err;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  icache_refill_axi dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .line_valid(line_valid), .line_addr(line_addr), .line_data(line_data), .line_err(line_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
    logic         err;
  } line_exp_t;

  logic [31:0] crit_eq[$];
  line_exp_t   line_eq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  int crit_cyc = 0;
  int line_cyc = 0;
  int lines_seen = 0;
  int lines_pushed = 0;
  int crits_seen = 0;
  int crits_pushed = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic monitor();
    line_exp_t le;
    logic [31:0] ce;
    forever begin
      @(negedge clk);
      if (req_valid && req_ready) req_cyc = cyc;
      if (crit_valid) begin
        crits_seen++;
        crit_cyc = cyc;
        if (crit_eq.size() == 0) chk("crit_unexpected", 1'b1, 1'b0);
        else begin
          ce = crit_eq.pop_front();
          chk("crit_data", crit_data, ce);
        end
      end
      if (line_valid) begin
        lines_seen++;
        line_cyc = cyc;
        if (line_eq.size() == 0) chk("line_unexpected", 1'b1, 1'b0);
        else begin
          le = line_eq.pop_front();
          chk("line_addr", line_addr, le.addr);
          chk("line_data", line_data, le.data);
          chk("line_err", line_err, le.err);
        end
      end
    end
  endtask

  // One refill with the bench as AXI slave. Negative beat indices disable that stimulus.
  task automatic refill(input logic [31:0] addr, input logic [31:0] seed, input int ar_delay,
                        input bit toggle, input int bad_resp_beat, input int early_last_beat,
                        input int reset_beat, input bit check_lat);
    logic [31:0]  d[W];
    logic [255:0] exp_line;
    logic [31:0]  exp_araddr;
    logic [2:0]   off;
    int           crit_beat;
    int           wi;
    int           snap;
    line_exp_t    le;

    off        = addr[4:2];
    crit_beat  = CWF ? 0 : int'(off);
    exp_araddr = CWF ? (addr & ~32'h3) : (addr & ~32'h1F);
    exp_line   = '0;
    for (int k = 0; k < W; k++) begin
      d[k] = seed ^ (32'h0101_0101 * (k + 1));
      wi   = CWF ? ((int'(off) + k) % W) : k;
      exp_line[wi*32 +: 32] = d[k];
    end
    if (reset_beat < 0 || crit_beat < reset_beat) begin
      crit_eq.push_back(d[crit_beat]);
      crits_pushed++;
    end
    if (reset_beat < 0) begin
      le.addr = addr & ~32'h1F;
      le.data = exp_line;
      le.err  = (bad_resp_beat >= 0) || (early_last_beat >= 0);
      line_eq.push_back(le);
      lines_pushed++;
    end
    snap = lines_seen;

    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF;
    arready   = (ar_delay == 0);
    for (int i = 0; i < ar_delay; i++) begin
      @(negedge clk);
      chk("ar_hold", {arvalid, araddr, arlen, arsize, arburst, arid, req_ready, rready},
          {1'b1, exp_araddr, 8'd7, 3'b010, (CWF ? 2'b10 : 2'b01), 4'd0, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    arready = 1'b1;
    @(negedge clk);
    chk("ar_handshake", {arvalid, araddr, arlen, arsize, arburst, arid, req_ready, rready},
        {1'b1, exp_araddr, 8'd7, 3'b010, (CWF ? 2'b10 : 2'b01), 4'd0, 1'b0, 1'b0});
    @(posedge clk); #1;
    arready = 1'b0;

    for (int k = 0; k < W; k++) begin
      if (toggle && k > 0) begin
        rvalid = 1'b0;
        @(posedge clk); #1;
      end
      rvalid = 1'b1;
      rdata  = d[k];
      rresp  = (k == bad_resp_beat) ? 2'b10 : 2'b00;
      rlast  = (k == W-1) || (k == early_last_beat);
      if (k == reset_beat) begin
        #2 resetn = 1'b0;
        #1;
        chk("rst_ctrl_clear", {arvalid, rready, crit_valid, line_valid, line_err, req_ready}, 6'b000001);
        chk("rst_line_clear", line_data, 256'd0);
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        @(posedge clk); #3;
        resetn = 1'b1;
        return;
      end
      @(negedge clk);
      if (k == W-1) chk("no_early_line", lines_seen, snap);
      chk("rready_beat", rready, 1'b1);
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;

    for (int i = 0; i < 12 && lines_seen == snap; i++) @(negedge clk);
    chk("line_arrived", lines_seen, snap + 1);
    if (check_lat) begin
      chk("line_latency", line_cyc - req_cyc, W + 2);
      chk("crit_latency", crit_cyc - req_cyc, crit_beat + 3);
    end
    @(negedge clk);
    chk("idle_after_line", {req_ready, line_valid, rready}, 3'b100);
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    arready   = 1'b0;
    rid       = 4'd0;
    rdata     = '0;
    rresp     = 2'b00;
    rlast     = 1'b0;
    rvalid    = 1'b0;
    fork
      tick();
      monitor();
    join_none

    // Reset state
    #12;
    chk("reset_ctrl", {arvalid, rready, crit_valid, line_valid, line_err, req_ready}, 6'b000001);
    chk("reset_line", line_data, 256'd0);
    #10 resetn = 1'b1;

    // Zero-wait burst with latency checks
    refill(32'h1FC0_0014, 32'hD000_0000, 0, 1'b0, -1, -1, -1, 1'b1);
    // arready stalled 5 cycles, rvalid toggling
    refill(32'h0000_1238, 32'h5A5A_0000, 5, 1'b1, -1, -1, -1, 1'b0);
    // SLVERR-style response on beat 3
    refill(32'h2000_0004, 32'h1234_5678, 0, 1'b0, 3, -1, -1, 1'b0);
    // Early rlast on beat 6; critical word is also the last beat here in INCR mode
    refill(32'h3000_001C, 32'hCAFE_0000, 1, 1'b0, -1, 6, -1, 1'b0);
    // Reset during beat 4, then a fresh request
    refill(32'h1FC0_0014, 32'hBAD0_0000, 0, 1'b0, -1, -1, 4, 1'b0);
    refill(32'h0000_0040, 32'h0F0F_0000, 0, 1'b0, -1, -1, -1, 1'b1);

    repeat (3) @(negedge clk);
    chk("crit_queue_empty", crit_eq.size(), 0);
    chk("line_queue_empty", line_eq.size(), 0);
    chk("line_pulse_count", lines_seen, lines_pushed);
    chk("crit_pulse_count", crits_seen, crits_pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill_axi.md
Name: icache_refill_axi

Overview:
- Miss-refill engine directly downstream of the instruction cache.
- Takes one line-refill request from the icache cacheout stage and issues a single AXI4 read burst.
- Assembles the returned beats into a full cache line and hands it back to the cache.
- Delivers the critical (requested) word early so fetch can resume before the whole line has arrived.

Parameters:
- ADDR_WIDTH, 32, address width in bits.
- BLOCK_SIZE, 5, log2 of the line size in bytes (32 B line = 8 words).
- AXI_ID, 4'd0, constant ARID driven on every request.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  refill request from the icache.
- req_ready  out  1  engine idle and able to accept a request.
- req_addr  in  ADDR_WIDTH  miss address; bits [1:0] are ignored.
- crit_valid  out  1  one-cycle pulse: the critical word is available.
- crit_data  out  32  critical word.
- line_valid  out  1  one-cycle pulse: the whole line is assembled.
- line_addr  out  ADDR_WIDTH  line base address (offset bits zero).
- line_data  out  2^(BLOCK_SIZE+3)  line contents; word i occupies bits [32i+31:32i].
- line_err  out  1  qualified by line_valid: any RRESP[1] set, or RLAST placed wrongly.
- arid  out  4  AXI read-address ID.
- araddr  out  ADDR_WIDTH  AXI read address.
- arlen  out  8  AXI burst length.
- arsize  out  3  AXI beat size.
- arburst  out  2  AXI burst type.
- arvalid  out  1  AXI read-address valid.
- arready  in  1  AXI read-address ready.
- rid  in  4  AXI read ID.
- rdata  in  32  AXI read data.
- rresp  in  2  AXI read response.
- rlast  in  1  AXI last beat.
- rvalid  in  1  AXI read-data valid.
- rready  out  1  AXI read-data ready.

Behaviour:
- Definitions:
  - W = 2^(BLOCK_SIZE-2) words per line.
  - off = req_addr[BLOCK_SIZE-1:2], the requested word offset.
- Reset (resetn low, asynchronous): the state machine enters IDLE; all of the following are 0:
  - arvalid, rready, crit_valid, line_valid, line_err;
  - the beat counter and the word pointer;
  - line_data.
  - A reset mid-burst abandons the transaction with no recovery; the system resets the interconnect together with this block.
- IDLE:
  - req_ready=1.
  - On req_valid: latch the word-aligned address and off, clear the error flag, move to AR.
- AR:
  - arvalid=1, arid=AXI_ID, arlen=W-1, arsize=3'b010.
  - araddr and arburst are set by the optional feature below.
  - All AR signals hold stable until arready; on handshake move to R.
- R:
  - rready=1. Each rvalid&rready beat writes rdata into line word ptr; ptr is then incremented modulo W (wrap-around).
  - The beat counter advances 0..W-1.
  - Critical word: on the beat whose ptr equals off, crit_valid pulses on the next cycle, with crit_data equal to that beat's data.
  - Error flag is set on any of:
    - rresp[1]=1;
    - rlast=1 on a beat other than count W-1;
    - rlast=0 on beat W-1.
  - The beat counter, not rlast, ends the burst: on beat W-1 move to DONE.
- DONE:
  - line_valid=1 for exactly one cycle.
  - line_addr = latched base address.
  - line_err = error flag.
  - Return to IDLE.
- Timing:
  - req_ready is low in AR, R and DONE; back-to-back requests are accepted only from IDLE, so the minimum request-to-request spacing is W+3 cycles.
  - rready is never asserted outside R; rvalid arriving early is left pending.
  - rid is not checked: only one outstanding transaction exists.
- Latency with zero-wait AXI: request accepted at cycle 0, AR handshake at 1, beats at 2..W+1, line_valid at W+2.
- Simultaneous events: the crit_valid pulse and the line_valid pulse coincide when the critical word is the last beat; both are asserted in the same cycle.

Optional Feature:
- Macro: ICACHE_REFILL_CWF_EN.
- Defined (critical word first):
  - arburst=2'b10 (WRAP), araddr = word-aligned req_addr, ptr starts at off.
  - The critical word is the first beat.
- Undefined:
  - arburst=2'b01 (INCR), araddr = line base, ptr starts at 0.
  - crit_valid fires after beat number off.

Test Plan:
- CWF defined, req_addr=0x1FC00014, beats D0..D7 zero-wait:
  - araddr=0x1FC00014, arlen=7, arburst=2'b10;
  - crit_valid with crit_data=D0 one cycle after first beat;
  - line word5=D0, word6=D1, word7=D2, word0=D3 ... word4=D7;
  - line_addr=0x1FC00000, line_valid at cycle 10, line_err=0.
- CWF undefined, same request:
  - araddr=0x1FC00000, arburst=2'b01;
  - crit_valid with D5 one cycle after the sixth beat;
  - word i = Di.
- arready held low 5 cycles, rvalid toggling 1-0-1-0:
  - AR signals stable throughout;
  - all 8 words land correctly;
  - line_valid exactly once.
- rresp=2'b10 on beat 3 → line_err=1 with line_valid; data still written.
- rlast asserted on beat 6 → line_err=1; burst still ends after 8 beats.
- resetn pulled low during beat 4, then a new request for 0x00000040:
  - outputs cleared immediately;
  - new line returned correctly, no stale words.
